present_cipher_core: RTL and testbench

PRESENT_CIPHER_CORE -- requirements
Module: present_cipher_core

---
 rtl/present_cipher_core.sv | 183 ++++++++++++++++++
 tb/tb_present_cipher_core.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_cipher_core.sv
// PRESENT block cipher core with iterative rounds, 80- or 128-bit key, encrypt and decrypt.
// Decryption first runs the key schedule forward to the last round key, then unwinds it.
module present_cipher_core #(
    parameter int KEY_SIZE = 80,
    parameter int ROUNDS   = 31
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                decrypt,
    input  logic [KEY_SIZE-1:0] key_in,
    input  logic [63:0]         data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         data_out,
    output logic                busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // sender holds its fields stable while valid is high and ready is low.

    typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} fsm_t;

    localparam logic [4:0] LAST = 5'(ROUNDS);

    fsm_t                fsm_q, fsm_d;
    logic [63:0]         state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                dec_q, dec_d;
    logic [63:0]         dout_q, dout_d;

    logic [KEY_SIZE-1:0] key_fwd, key_inv;
    logic [63:0]         round_key, add_key, sub_out, enc_round, invp_out, dec_round;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    assign round_key = key_q[KEY_SIZE-1 -: 64];
    assign add_key   = state_q ^ round_key;

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign sub_out[4*n +: 4]   = sbox(add_key[4*n +: 4]);
        assign dec_round[4*n +: 4] = inv_sbox(invp_out[4*n +: 4]);
    end

    // Bit i of the S-box output moves to position 16*i mod 63; bit 63 stays.
    for (genvar i = 0; i < 64; i++) begin : g_perm
        localparam int P = (i == 63) ? 63 : (i * 16) % 63;
        assign enc_round[P] = sub_out[i];
        assign invp_out[i]  = add_key[P];
    end

    if (KEY_SIZE == 128) begin : g_key128
        logic [127:0] f, b;
        always_comb begin
            f = {key_q[66:0], key_q[127:67]};
            f[127:124] = sbox(f[127:124]);
            f[123:120] = sbox(f[123:120]);
            f[66:62]   = f[66:62] ^ cnt_q;
            key_fwd    = f;
            b          = key_q;
            b[66:62]   = b[66:62] ^ cnt_q;
            b[127:124] = inv_sbox(b[127:124]);
            b[123:120] = inv_sbox(b[123:120]);
            key_inv    = {b[60:0], b[127:61]};
        end
    end else begin : g_key80
        logic [79:0] f, b;
        always_comb begin
            f = {key_q[18:0], key_q[79:19]};
            f[79:76] = sbox(f[79:76]);
            f[19:15] = f[19:15] ^ cnt_q;
            key_fwd  = f;
            b        = key_q;
            b[19:15] = b[19:15] ^ cnt_q;
            b[79:76] = inv_sbox(b[79:76]);
            key_inv  = {b[60:0], b[79:61]};
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        dout_d  = dout_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = data_in;
                    key_d   = key_in;
                    dec_d   = decrypt;
                    cnt_d   = 5'd1;
                    fsm_d   = decrypt ? KEYEXP : RUN;
                end
            end
            KEYEXP: begin
                key_d = key_fwd;
                if (cnt_q == LAST) begin
                    fsm_d = RUN;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            RUN: begin
                if (!dec_q) begin
                    key_d = key_fwd;
                    // The counter holds on the last round so it never exceeds 5 bits.
                    if (cnt_q == LAST) begin
                        state_d = enc_round ^ key_fwd[KEY_SIZE-1 -: 64];
                        dout_d  = enc_round ^ key_fwd[KEY_SIZE-1 -: 64];
                        fsm_d   = DONE;
                    end else begin
                        state_d = enc_round;
                        cnt_d   = cnt_q + 5'd1;
                    end
                end else begin
                    key_d = key_inv;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = dec_round ^ key_inv[KEY_SIZE-1 -: 64];
                        dout_d  = dec_round ^ key_inv[KEY_SIZE-1 -: 64];
                        fsm_d   = DONE;
                    end else begin
                        state_d = dec_round;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            dout_q  <= dout_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = (fsm_q == DONE);
    assign data_out  = dout_q;

endmodule

// File: tb/tb_present_cipher_core.sv
// Bench for present_cipher_core: 80-bit and 128-bit instances share the request bus,
// a reference PRESENT model predicts every result and its latency.
module tb_present_cipher_core;

    localparam int ROUNDS = 31;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         decrypt = 1'b0;
    logic         out_ready = 1'b0;
    logic         sel = 1'b0;
    logic [127:0] key_bus = '0;
    logic [63:0]  data_in = '0;

    logic         in_ready_a, out_valid_a, busy_a;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [63:0]  data_out_a, data_out_b;
    logic         mon_in_ready, mon_out_valid, mon_busy;
    logic [63:0]  mon_data_out;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res [2] = '{64'h0, 64'h0};

    logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] isb [16];

    present_cipher_core #(.KEY_SIZE(80), .ROUNDS(ROUNDS)) dut_a (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid & ~sel), .in_ready(in_ready_a),
        .decrypt(decrypt), .key_in(key_bus[79:0]), .data_in(data_in),
        .out_valid(out_valid_a), .out_ready(out_ready), .data_out(data_out_a), .busy(busy_a)
    );

    present_cipher_core #(.KEY_SIZE(128), .ROUNDS(ROUNDS)) dut_b (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid & sel), .in_ready(in_ready_b),
        .decrypt(decrypt), .key_in(key_bus), .data_in(data_in),
        .out_valid(out_valid_b), .out_ready(out_ready), .data_out(data_out_b), .busy(busy_b)
    );

    assign mon_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign mon_out_valid = sel ? out_valid_b : out_valid_a;
    assign mon_busy      = sel ? busy_b      : busy_a;
    assign mon_data_out  = sel ? data_out_b  : data_out_a;

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference model: full round-key list first, then the textbook round sequence.
    function automatic logic [63:0] model_cipher(input logic [127:0] key, input int ks,
                                                 input bit dec, input logic [63:0] din);
        logic [127:0] k;
        logic [63:0]  rk [1:32];
        logic [63:0]  s, t;
        int           p;
        k = (ks == 80) ? (key & {48'h0, {80{1'b1}}}) : key;
        for (int r = 1; r <= ROUNDS + 1; r++) begin
            if (ks == 80) begin
                rk[r] = k[79:16];
                k = ((k << 61) | (k >> 19)) & {48'h0, {80{1'b1}}};
                k[79:76] = sb[k[79:76]];
                k = k ^ (128'(r) << 15);
            end else begin
                rk[r] = k[127:64];
                k = (k << 61) | (k >> 67);
                k[127:124] = sb[k[127:124]];
                k[123:120] = sb[k[123:120]];
                k = k ^ (128'(r) << 62);
            end
        end
        if (!dec) begin
            s = din;
            for (int r = 1; r <= ROUNDS; r++) begin
                s = s ^ rk[r];
                for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
                t = '0;
                for (int i = 0; i < 64; i++) begin
                    p = (i == 63) ? 63 : (i * 16) % 63;
                    t[p] = s[i];
                end
                s = t;
            end
            s = s ^ rk[ROUNDS + 1];
        end else begin
            s = din ^ rk[ROUNDS + 1];
            for (int r = ROUNDS; r >= 1; r--) begin
                t = '0;
                for (int i = 0; i < 64; i++) begin
                    p = (i == 63) ? 63 : (i * 16) % 63;
                    t[i] = s[p];
                end
                s = t;
                for (int n = 0; n < 16; n++) s[4*n +: 4] = isb[s[4*n +: 4]];
                s = s ^ rk[r];
            end
        end
        return s;
    endfunction

    // Compare process: result, stability in DONE and retention in IDLE, every cycle.
    always @(negedge Clock) begin
        if (Reset) begin
            exp_q.delete();
            last_res[0] = 64'h0;
            last_res[1] = 64'h0;
        end else if (mon_out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {63'h0, mon_out_valid}, 64'h0);
            end else begin
                check("data_out", mon_data_out, exp_q[0]);
                check("in_ready_in_done", {63'h0, mon_in_ready}, 64'h0);
                if (out_ready) last_res[sel] = exp_q.pop_front();
            end
        end else if (!mon_busy) begin
            check("data_out_idle", mon_data_out, last_res[sel]);
        end
    end

    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        in_valid = 1'b1;
        repeat (cycles) @(posedge Clock);
        #1;
        Reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rst_in_ready_a", {63'h0, in_ready_a}, 64'h1);
        check("rst_busy_a", {63'h0, busy_a}, 64'h0);
        check("rst_out_valid_a", {63'h0, out_valid_a}, 64'h0);
        check("rst_data_out_a", data_out_a, 64'h0);
        check("rst_busy_b", {63'h0, busy_b}, 64'h0);
        check("rst_data_out_b", data_out_b, 64'h0);
    endtask

    task automatic start_req(input bit s, input bit dec, input logic [127:0] key,
                             input logic [63:0] din, input bit rdy_early);
        sel = s;
        check("in_ready_before_req", {63'h0, mon_in_ready}, 64'h1);
        check("busy_before_req", {63'h0, mon_busy}, 64'h0);
        decrypt = dec;
        key_bus = key;
        data_in = din;
        in_valid = 1'b1;
        out_ready = rdy_early;
        exp_q.push_back(model_cipher(key, s ? 128 : 80, dec, din));
        @(posedge Clock);
        #1;
        in_valid = 1'b0;
        key_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
        data_in = {$urandom(), $urandom()};
        decrypt = ~dec;
    endtask

    task automatic wait_done(input int lat, input int hold);
        int n = 0;
        bit got = 1'b0;
        while (n < lat + 5 && !got) begin
            @(posedge Clock);
            #1;
            n++;
            if (mon_out_valid) got = 1'b1;
            else begin
                check("busy_running", {63'h0, mon_busy}, 64'h1);
                check("in_ready_running", {63'h0, mon_in_ready}, 64'h0);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: no out_valid within %0d cycles, required %0d", n, lat);
            do_reset(2);
            return;
        end
        check("latency", 64'(n), 64'(lat));
        if (!out_ready) begin
            repeat (hold) begin
                in_valid = 1'b1;
                key_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
                data_in = {$urandom(), $urandom()};
                @(posedge Clock);
                #1;
                check("out_valid_held", {63'h0, mon_out_valid}, 64'h1);
            end
            out_ready = 1'b1;
        end
        @(posedge Clock);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("out_valid_after_ack", {63'h0, mon_out_valid}, 64'h0);
        check("in_ready_after_ack", {63'h0, mon_in_ready}, 64'h1);
        check("busy_after_ack", {63'h0, mon_busy}, 64'h0);
    endtask

    localparam logic [127:0] K0   = 128'h0;
    localparam logic [127:0] K1   = {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF};
    localparam logic [63:0]  ONES = 64'hFFFFFFFFFFFFFFFF;

    initial begin
        logic [127:0] rkey;
        logic [63:0]  rdat;
        for (int i = 0; i < 16; i++) isb[sb[i]] = 4'(i);

        check("model_k0_p0", model_cipher(K0, 80, 0, 64'h0), 64'h5579C1387B228445);
        check("model_k1_p0", model_cipher(K1, 80, 0, 64'h0), 64'hE72C46C0F5945049);
        check("model_k0_p1", model_cipher(K0, 80, 0, ONES), 64'hA112FFC72F68417B);
        check("model_k1_p1", model_cipher(K1, 80, 0, ONES), 64'h3333DCD3213210D2);
        check("model_dec_k0", model_cipher(K0, 80, 1, 64'h5579C1387B228445), 64'h0);
        check("model_128_k0", model_cipher(K0, 128, 0, 64'h0), 64'h96DB702A2E6900AF);

        do_reset(3);

        start_req(0, 0, K0, 64'h0, 0);   wait_done(ROUNDS, 0);
        start_req(0, 0, K1, 64'h0, 1);   wait_done(ROUNDS, 0);
        start_req(0, 0, K0, ONES, 0);    wait_done(ROUNDS, 3);
        start_req(0, 0, K1, ONES, 0);    wait_done(ROUNDS, 1);
        start_req(0, 1, K0, 64'h5579C1387B228445, 0); wait_done(2 * ROUNDS, 2);
        start_req(0, 1, K1, 64'h3333DCD3213210D2, 1); wait_done(2 * ROUNDS, 0);

        // Long stall in DONE with a competing request and key changes on the bus.
        start_req(0, 0, K1, 64'h0123456789ABCDEF, 0); wait_done(ROUNDS, 10);

        start_req(1, 0, K0, 64'h0, 0);   wait_done(ROUNDS, 1);
        start_req(1, 1, K0, 64'h96DB702A2E6900AF, 0); wait_done(2 * ROUNDS, 0);

        // Reset in the middle of round 15 discards the result.
        start_req(0, 0, K1, 64'hDEADBEEFCAFEF00D, 0);
        repeat (14) @(posedge Clock);
        #1;
        do_reset(1);
        repeat (40) begin
            @(posedge Clock);
            #1;
            check("no_stale_out_valid", {63'h0, out_valid_a}, 64'h0);
        end
        start_req(0, 0, K0, 64'h0, 0);   wait_done(ROUNDS, 1);

        for (int j = 0; j < 4; j++) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            rdat = {$urandom(), $urandom()};
            start_req(j[0], j[1], rkey, rdat, j[0]);
            wait_done(j[1] ? 2 * ROUNDS : ROUNDS, j);
        end

        repeat (3) @(posedge Clock);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
